// File: rtl/de1_soc_leds_pio.sv
// Avalon-MM LED output port: data register with atomic set/clear and an optional
// hardware blink engine, enabled by defining DE1_SOC_LEDS_BLINK_EN.
module de1_soc_leds_pio #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    // Bus handshake: a write is accepted on every rising edge where chipselect is
    // high and write_n is low (no waitrequest); reads always return one cycle later.
    logic        w_write;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic [WIDTH-1:0] r_data;
    logic [31:0]      r_readdata;

    assign w_write  = chipselect & ~write_n;
    assign w_unused = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
        end else if (w_write && address == 2'd0) begin
            r_data <= writedata[WIDTH-1:0];
        end else if (w_write && address == 2'd3) begin
            if (writedata[31]) begin
                r_data <= r_data & ~writedata[WIDTH-1:0];
            end else begin
                r_data <= r_data | writedata[WIDTH-1:0];
            end
        end
    end

`ifdef DE1_SOC_LEDS_BLINK_EN
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_write && address == 2'd1) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // A period write restarts the half-cycle and wins over a toggle on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (w_write && address == 2'd2) begin
            r_period <= writedata[CNT_W-1:0];
            r_cnt    <= writedata[CNT_W-1:0];
            r_phase  <= 1'b0;
        end else if (r_period == '0) begin
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt    <= r_period;
            r_phase  <= ~r_phase;
        end else begin
            r_cnt    <= r_cnt - CNT_W'(1);
        end
    end

    assign out_port = r_data ^ (r_mask & {WIDTH{r_phase}});
`else
    assign out_port = r_data;
`endif

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0: w_rdata[WIDTH-1:0] = r_data;
`ifdef DE1_SOC_LEDS_BLINK_EN
            2'd1: w_rdata[WIDTH-1:0] = r_mask;
            2'd2: w_rdata[CNT_W-1:0] = r_period;
            2'd3: w_rdata[0]         = r_phase;
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign readdata = r_readdata;

endmodule

// File: tb/tb_de1_soc_leds_pio.sv
// Directed bench for de1_soc_leds_pio: register table plus blink/reset sequences.
module tb_de1_soc_leds_pio;

    localparam int WIDTH = 10;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int total;
    int bad;

    typedef struct {
        logic        is_read;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[32];
    int   n_vecs;

    de1_soc_leds_pio #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(10'h155),
        .CNT_W      (24)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rd, input logic [1:0] a, input logic [31:0] wd,
                           input logic [31:0] e);
        vecs[n_vecs].is_read = rd;
        vecs[n_vecs].addr    = a;
        vecs[n_vecs].wdata   = wd;
        vecs[n_vecs].exp     = e;
        n_vecs++;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
    endtask

    task automatic do_read(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        n_vecs     = 0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;

        repeat (2) @(negedge clk);
        check("reset_out", {22'b0, out_port}, 32'h155);
        check("reset_rd", readdata, 32'h0);
        reset_n = 1'b1;

        // Table entries: reads compare readdata, writes compare out_port.
        add_vec(1'b1, 2'd0, 32'h0, 32'h155);
        add_vec(1'b0, 2'd0, 32'hFFFF_F3A5, 32'h3A5);
        add_vec(1'b1, 2'd0, 32'h0, 32'h3A5);
        add_vec(1'b0, 2'd0, 32'h0000_00F0, 32'h0F0);
        add_vec(1'b0, 2'd3, 32'h0000_0003, 32'h0F3);
        add_vec(1'b0, 2'd3, 32'h8000_0030, 32'h0C3);
        add_vec(1'b1, 2'd0, 32'h0, 32'h0C3);
        add_vec(1'b1, 2'd3, 32'h0, 32'h0);
        add_vec(1'b0, 2'd3, 32'h8000_03FF, 32'h000);
        add_vec(1'b0, 2'd3, 32'h0000_03FF, 32'h3FF);
        add_vec(1'b0, 2'd0, 32'h0, 32'h000);
`ifdef DE1_SOC_LEDS_BLINK_EN
        add_vec(1'b0, 2'd1, 32'hFFFF_FFFF, 32'h000);
        add_vec(1'b1, 2'd1, 32'h0, 32'h3FF);
        add_vec(1'b0, 2'd2, 32'hFF00_0000, 32'h000);
        add_vec(1'b1, 2'd2, 32'h0, 32'h0);
        add_vec(1'b0, 2'd2, 32'h0012_3456, 32'h000);
        add_vec(1'b1, 2'd2, 32'h0, 32'h0012_3456);
        add_vec(1'b0, 2'd2, 32'h0, 32'h000);
        add_vec(1'b0, 2'd1, 32'h0, 32'h000);
        add_vec(1'b1, 2'd1, 32'h0, 32'h0);
`else
        add_vec(1'b0, 2'd1, 32'h0000_03FF, 32'h000);
        add_vec(1'b1, 2'd1, 32'h0, 32'h0);
        add_vec(1'b0, 2'd2, 32'h0000_03FF, 32'h000);
        add_vec(1'b1, 2'd2, 32'h0, 32'h0);
        add_vec(1'b0, 2'd3, 32'h0000_0000, 32'h000);
`endif

        for (int i = 0; i < n_vecs; i++) begin
            if (vecs[i].is_read) begin
                do_read(vecs[i].addr);
                check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp);
            end else begin
                do_write(vecs[i].addr, vecs[i].wdata);
                check($sformatf("vec%0d_out", i), {22'b0, out_port}, vecs[i].exp);
            end
        end

`ifdef DE1_SOC_LEDS_BLINK_EN
        // Basic blink: period 4 gives a toggle every 5 edges after the period write.
        do_write(2'd0, 32'h0);
        do_write(2'd1, 32'h1);
        do_write(2'd2, 32'd4);
        check("blink_start", {22'b0, out_port}, 32'h0);
        address = 2'd3;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("blink_out_k%0d", k), {22'b0, out_port}, 32'((k / 5) % 2));
            check($sformatf("blink_ph_k%0d", k), readdata, 32'(((k - 1) / 5) % 2));
        end
        do_write(2'd2, 32'd0);
        check("blink_stop", {22'b0, out_port}, 32'h0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("blink_stay_k%0d", k), {22'b0, out_port}, 32'h0);
        end

        // Period write on the edge where the counter has reached zero.
        do_write(2'd2, 32'd4);
        repeat (4) @(negedge clk);
        do_write(2'd2, 32'd3);
        check("period_on_zero", {22'b0, out_port}, 32'h0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check($sformatf("restart_j%0d", j), {22'b0, out_port}, (j == 4) ? 32'h1 : 32'h0);
        end

        // DATA write landing on the same edge as a toggle back to phase 0.
        repeat (3) @(negedge clk);
        do_write(2'd0, 32'h300);
        check("data_with_toggle", {22'b0, out_port}, 32'h300);
        do_read(2'd3);
        check("phase_after_toggle", readdata, 32'h0);
`endif

        // Asynchronous reset between clock edges.
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_out", {22'b0, out_port}, 32'h155);
        check("async_rst_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        do_read(2'd1);
        check("post_rst_mask", readdata, 32'h0);
        do_read(2'd2);
        check("post_rst_period", readdata, 32'h0);
        do_read(2'd3);
        check("post_rst_phase", readdata, 32'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_out_k%0d", k), {22'b0, out_port}, 32'h155);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/de1_soc_leds_pio.md
# de1_soc_leds_pio

Avalon-MM write/read output port driving the DE1-SoC LED bank (or any active-high output group) from the HPS/Nios bus; the output-direction counterpart of the board's key input port. Holds a software-written data register, supports atomic bit set/clear, and optionally a hardware blink engine that toggles masked bits at a programmable rate without CPU involvement. Sits on the lightweight bridge alongside the other board PIOs.

## Interface
- WIDTH, 10, number of output bits (1–31)
- RESET_VALUE, 0, value of data register after reset
- CNT_W, 24, width of blink period register/counter
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  2  word address within the slave
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe; write = chipselect & ~write_n
- writedata  input  32  write data
- readdata  output  32  registered read data
- out_port  output  WIDTH  LED drive

## Operation
- Register map (word addresses):
  - 0 DATA: R/W, data_reg = writedata[WIDTH-1:0].
  - 1 BLINK_MASK: R/W, bits of data allowed to blink.
  - 2 BLINK_PERIOD: R/W, CNT_W bits; 0 = blink disabled.
  - 3 SETCLR/STATUS: write with writedata[31]=0 → data_reg |= writedata[WIDTH-1:0]; writedata[31]=1 → data_reg &= ~writedata[WIDTH-1:0]. Read returns {31'b0, phase}.
- Unused upper readdata bits read 0; writedata bits above WIDTH (or CNT_W) ignored.
- Blink engine: down-counter cnt, phase bit.
  - period==0: cnt held 0, phase held 0.
  - period!=0: if cnt==0 → phase toggles, cnt ← period; else cnt ← cnt-1. Half-period = period+1 cycles.
  - Any write to BLINK_PERIOD: cnt ← new value, phase ← 0 (write overrides same-cycle toggle).
- out_port = data_reg ^ (mask & {WIDTH{phase}}), purely from registered state.
- Simultaneous: DATA/SETCLR write and phase toggle in same cycle both take effect. Writes to different registers cannot coincide (single port).

## Timing
- Reset values: data_reg=RESET_VALUE, mask=0, period=0, cnt=0, phase=0, readdata=0, out_port=RESET_VALUE.
- Write: captured on the rising edge where write is high; out_port reflects it immediately after that edge (0 wait states, no waitrequest).
- Read: readdata updated every clock from current address (fixed read latency 1); value reflects state before any write on the same edge.
- Blink: first toggle occurs period+1 edges after the period write edge.
- Reset asserted mid-operation: all state returns to reset values asynchronously; blinking stops, out_port=RESET_VALUE until new writes.

## Configuration
- DE1_SOC_LEDS_BLINK_EN defined: blink engine, BLINK_MASK, BLINK_PERIOD, and phase status present as above.
- Not defined: no counter/mask/period/phase logic; addresses 1 and 2 read 0 and ignore writes; address 3 reads 0 (SETCLR writes still work); out_port = data_reg.

## Test plan
- Reset with RESET_VALUE=10'h155 → out_port=10'h155, readdata=0; read addr 0 → 32'h155 one cycle later.
- Write DATA 32'hFFFF_F3A5 → out_port=10'h3A5 next cycle; read addr 0 → 32'h3A5.
- From DATA=10'h0F0: SETCLR write 32'h0000_0003 → 10'h0F3; then 32'h8000_0030 → 10'h0C3.
- Blink (macro on): DATA=0, mask=10'h001, period=4 → out_port[0] toggles every 5 cycles; addr 3 read tracks phase; period write of 0 → out_port[0]=0 and stays.
- Period write on the cycle cnt==0 → phase forced 0, no toggle, next toggle period+1 cycles later; DATA write coincident with toggle → both visible.
- Assert reset_n mid-blink (async, between edges) → out_port=RESET_VALUE immediately, mask/period read 0; macro off build → addr 1/2 write 32'h3FF then read 0, out_port unaffected.
